// File: rtl/prime_sieve.sv
// prime_sieve: Sieve of Eratosthenes over 0..N held in an (N+1) x 1 mark memory.
// A start pulse clears the memory, then strikes out the multiples of every
// prime i with i*i <= N. After that, primality queries are answered from the
// memory.
// Optional feature macro: PRIME_SIEVE_COUNT_EN. When it is defined, a COUNT
// pass totals the surviving marks into prime_count. When it is not defined,
// prime_count is tied to 0.
//
// state | meaning
// IDLE  | after reset, waiting for start
// INIT  | write mark[0..N] (0 for 0 and 1, 1 otherwise), one address per cycle
// SCAN  | issue a read of mark[i], then use the result one cycle later
// MARK  | clear mark[j] for j = i*i, i*i+i, ... up to N
// COUNT | read mark[0..N] and accumulate set bits (feature build only)
// DONE  | result valid, queries served, start re-runs
module prime_sieve #(
  parameter int N  = 1000,
  parameter int AW = 10,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          over,
  output logic [CW-1:0] prime_count,
  input  logic          q_req,
  input  logic [AW-1:0] q_addr,
  output logic          q_valid,
  output logic          q_is_prime
);

  localparam int MW = $clog2(N + 1);
  localparam logic [AW:0]     N_W   = (AW+1)'(N);
  localparam logic [AW:0]     TWO_W = (AW+1)'(2);
  localparam logic [AW-1:0]   TWO_A = AW'(2);
  localparam logic [2*AW-1:0] N_SQ  = (2*AW)'(N);
`ifdef PRIME_SIEVE_COUNT_EN
  localparam logic [AW:0]     N_P1  = (AW+1)'(N + 1);
`endif

  typedef enum logic [2:0] {IDLE, INIT, SCAN, MARK, COUNT, DONE} state_t;

  state_t state, state_nx;

  logic            mem [0:N];
  logic [AW:0]     cnt;
  logic [AW:0]     j;
  logic [AW:0]     j_nx;
  logic [AW-1:0]   i;
  logic [AW-1:0]   ra;
  logic [MW-1:0]   wa;
  logic [2*AW-1:0] i_sq;
  logic            scan_wait;
  logic            we;
  logic            wd;
  logic            rd_data;

  // i*i is formed at full double width so the loop bound never wraps
  assign i_sq = {{AW{1'b0}}, i} * {{AW{1'b0}}, i};
  assign j_nx = j + {1'b0, i};

  assign busy = (state != IDLE) && (state != DONE);
  assign over = (state == DONE);

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state decode and mark-memory port control
  always_comb begin
    state_nx = state;
    we       = 1'b0;
    wa       = '0;
    wd       = 1'b0;
    ra       = q_addr;
    case (state)
      IDLE, DONE: begin
        if (start) state_nx = INIT;
      end
      INIT: begin
        we = 1'b1;
        wa = cnt[MW-1:0];
        wd = (cnt >= TWO_W);
        if (cnt == N_W) state_nx = SCAN;
      end
      SCAN: begin
        ra = i;
        if (!scan_wait) begin
          if (i_sq > N_SQ) begin
`ifdef PRIME_SIEVE_COUNT_EN
            state_nx = COUNT;
`else
            state_nx = DONE;
`endif
          end
        end else if (rd_data) begin
          state_nx = MARK;
        end
      end
      MARK: begin
        we = 1'b1;
        wa = j[MW-1:0];
        wd = 1'b0;
        if (j_nx > N_W) state_nx = SCAN;
      end
`ifdef PRIME_SIEVE_COUNT_EN
      COUNT: begin
        ra = cnt[AW-1:0];
        if (cnt == N_P1) state_nx = DONE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // mark memory: synchronous write, registered read; out-of-range reads return 0
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if ({1'b0, ra} <= N_W) rd_data <= mem[ra[MW-1:0]];
    else                   rd_data <= 1'b0;
  end

  // sieve counters: cnt walks INIT/COUNT, i is the candidate, j the multiple
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      i         <= '0;
      j         <= '0;
      scan_wait <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt       <= '0;
            i         <= TWO_A;
            j         <= '0;
            scan_wait <= 1'b0;
          end
        end
        INIT: cnt <= (cnt == N_W) ? '0 : cnt + 1'b1;
        SCAN: begin
          if (!scan_wait) begin
            if (i_sq > N_SQ) cnt <= '0;
            else             scan_wait <= 1'b1;
          end else begin
            scan_wait <= 1'b0;
            if (rd_data) j <= i_sq[AW:0];
            else         i <= i + 1'b1;
          end
        end
        MARK: begin
          j <= j_nx;
          if (j_nx > N_W) i <= i + 1'b1;
        end
`ifdef PRIME_SIEVE_COUNT_EN
        COUNT: cnt <= cnt + 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // query response: a start in the same DONE cycle drops the query
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_valid <= 1'b0;
    else       q_valid <= over && q_req && !start;
  end

  assign q_is_prime = q_valid & rd_data;

`ifdef PRIME_SIEVE_COUNT_EN
  logic [CW-1:0] acc;

  // prime accumulator; read data lags the COUNT address by one cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                   acc <= '0;
    else if (start && (state == IDLE || over))   acc <= '0;
    else if (state == COUNT && cnt != '0)        acc <= acc + CW'(rd_data);
  end

  assign prime_count = acc;
`else
  assign prime_count = '0;
`endif

endmodule

// File: tb/tb_prime_sieve.sv
// tb_prime_sieve: three sieve instances (N = 30, 2, 1000) driven by directed
// steps with random pokes and random queries. Expected values come from a
// trial-division prime model.
module tb_prime_sieve;

  localparam int AW = 10;
  localparam int CW = 10;
  localparam int NS [3] = '{30, 2, 1000};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] q_req_v = '0;
  logic [2:0] busy_v, over_v, q_valid_v, q_is_prime_v;
  logic [AW-1:0] q_addr_v [3];
  logic [CW-1:0] pc_v [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      prime_sieve #(.N(NS[g]), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start_v[g]),
        .busy       (busy_v[g]),
        .over       (over_v[g]),
        .prime_count(pc_v[g]),
        .q_req      (q_req_v[g]),
        .q_addr     (q_addr_v[g]),
        .q_valid    (q_valid_v[g]),
        .q_is_prime (q_is_prime_v[g])
      );
    end
  endgenerate

  function automatic bit ref_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int ref_count(input int n);
    int c = 0;
`ifdef PRIME_SIEVE_COUNT_EN
    for (int k = 0; k <= n; k++) c += int'(ref_prime(k));
`endif
    return c;
  endfunction

  function automatic bit ref_query(input int d, input int a);
    return (a <= NS[d]) && ref_prime(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int d);
    chk($sformatf("rst_busy[%0d]", d), 32'(busy_v[d]), 0);
    chk($sformatf("rst_over[%0d]", d), 32'(over_v[d]), 0);
    chk($sformatf("rst_count[%0d]", d), 32'(pc_v[d]), 0);
    chk($sformatf("rst_q_valid[%0d]", d), 32'(q_valid_v[d]), 0);
    chk($sformatf("rst_q_is_prime[%0d]", d), 32'(q_is_prime_v[d]), 0);
  endtask

  task automatic kick(input int d);
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    chk($sformatf("busy_after_start[%0d]", d), 32'(busy_v[d]), 1);
    chk($sformatf("over_cleared[%0d]", d), 32'(over_v[d]), 0);
  endtask

  // wait for over with a cycle bound; optionally poke start/q_req while busy
  task automatic wait_done(input int d, input bit poke);
    int cyc = 0;
    bit overlap = 1'b0;
    bit gap = 1'b0;
    bit spurious = 1'b0;
    while (!over_v[d] && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (busy_v[d] && over_v[d]) overlap = 1'b1;
      if (!busy_v[d] && !over_v[d]) gap = 1'b1;
      if (q_valid_v[d]) spurious = 1'b1;
      if (poke && !over_v[d]) begin
        start_v[d]  = ($urandom_range(0, 3) == 0);
        q_req_v[d]  = 1'($urandom_range(0, 1));
        q_addr_v[d] = AW'($urandom_range(0, NS[d]));
      end else begin
        start_v[d] = 1'b0;
        q_req_v[d] = 1'b0;
      end
    end
    start_v[d] = 1'b0;
    q_req_v[d] = 1'b0;
    chk($sformatf("run_finished[%0d]", d), 32'(over_v[d]), 1);
    chk($sformatf("busy_over_overlap[%0d]", d), 32'(overlap), 0);
    chk($sformatf("busy_gap[%0d]", d), 32'(gap), 0);
    chk($sformatf("q_valid_before_over[%0d]", d), 32'(spurious), 0);
    chk($sformatf("busy_low_at_over[%0d]", d), 32'(busy_v[d]), 0);
  endtask

  // back-to-back queries, one per cycle, each answered on the following cycle
  task automatic query_burst(input int d, input int addrs[$]);
    for (int k = 0; k <= addrs.size(); k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("q_valid[%0d]@%0d", d, addrs[k-1]), 32'(q_valid_v[d]), 1);
        chk($sformatf("q_is_prime[%0d]@%0d", d, addrs[k-1]), 32'(q_is_prime_v[d]),
            32'(ref_query(d, addrs[k-1])));
      end
      if (k < addrs.size()) begin
        q_req_v[d]  = 1'b1;
        q_addr_v[d] = AW'(addrs[k]);
      end else begin
        q_req_v[d] = 1'b0;
      end
    end
    @(negedge clk);
    chk($sformatf("q_valid_idle[%0d]", d), 32'(q_valid_v[d]), 0);
  endtask

  initial begin
    int qa[$];
    for (int d = 0; d < 3; d++) q_addr_v[d] = '0;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) chk_reset_outputs(d);
    rstn = 1'b1;
    @(negedge clk);

    // a query before any run is ignored
    q_req_v[0] = 1'b1;
    q_addr_v[0] = AW'(29);
    @(negedge clk);
    q_req_v[0] = 1'b0;
    chk("q_before_run", 32'(q_valid_v[0]), 0);

    // N=30 run with ignored start/q_req pokes
    kick(0);
    wait_done(0, 1'b1);
    chk("count_n30", 32'(pc_v[0]), 32'(ref_count(30)));

    qa = '{2, 29, 25, 1, 0};
    query_burst(0, qa);

    qa = {};
    for (int k = 0; k < 40; k++)
      qa.push_back((k % 2 == 1) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 32)));
    query_burst(0, qa);
    chk("count_n30_held", 32'(pc_v[0]), 32'(ref_count(30)));
    chk("over_held", 32'(over_v[0]), 1);

    // start and query in the same DONE cycle: start wins, query dropped
    @(negedge clk);
    start_v[0] = 1'b1;
    q_req_v[0] = 1'b1;
    q_addr_v[0] = AW'(2);
    @(negedge clk);
    start_v[0] = 1'b0;
    q_req_v[0] = 1'b0;
    chk("collide_q_valid", 32'(q_valid_v[0]), 0);
    chk("collide_busy", 32'(busy_v[0]), 1);
    chk("collide_over", 32'(over_v[0]), 0);
    wait_done(0, 1'b1);
    chk("count_n30_rerun", 32'(pc_v[0]), 32'(ref_count(30)));

    // N=2 boundary
    kick(1);
    wait_done(1, 1'b0);
    chk("count_n2", 32'(pc_v[1]), 32'(ref_count(2)));
    qa = '{0, 1, 2, 3, 1023};
    query_burst(1, qa);

    // N=1000
    kick(2);
    wait_done(2, 1'b1);
    chk("count_n1000", 32'(pc_v[2]), 32'(ref_count(1000)));
    qa = '{997, 999, 2, 1000, 1001, 961, 1023};
    for (int k = 0; k < 20; k++) qa.push_back(int'($urandom_range(0, 1023)));
    query_burst(2, qa);

    // reset in the middle of the first MARK pass of an N=30 run
    kick(0);
    repeat (36) @(negedge clk);
    chk("still_busy_before_reset", 32'(busy_v[0]), 1);
    rstn = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_reset_outputs(d);
    rstn = 1'b1;
    @(negedge clk);
    q_req_v[0] = 1'b1;
    q_addr_v[0] = AW'(29);
    @(negedge clk);
    q_req_v[0] = 1'b0;
    chk("q_after_reset", 32'(q_valid_v[0]), 0);

    kick(0);
    wait_done(0, 1'b1);
    chk("count_n30_after_reset", 32'(pc_v[0]), 32'(ref_count(30)));
    qa = '{29, 30, 31, 4};
    query_burst(0, qa);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
